// File: rtl/sprite_blitter.sv
// sprite_blitter: write side of the 128x64 (hires) / 64x32 (lores) framebuffer.
// Executes Chip-8 DXYN / SCHIP DXY0 draws as a read-modify-write XOR of each
// sprite row into fbuf words (bit 15 = leftmost pixel) and reports VF collision.
//
// Ports:
//   clk, res          clock, synchronous active-high reset
//   hires             1: 128x64 (8 words/line), 0: 64x32 (4 words/line)
//   start             one-cycle draw request, only honoured while idle
//   x, y, n           sprite position and row count (n=0: 16x16 in hires, no-op in lores)
//   i_addr            sprite base address
//   mem_addr/mem_data sprite byte port, data returns one cycle after the address
//   fbuf_addr         framebuffer word address, shared by read and write
//   fbuf_rdata        word at fbuf_addr, one cycle after the address
//   fbuf_wdata/we     write data and one-cycle strobe
//   busy, done        busy outside IDLE; done pulses once per completed draw
//   collision         a set pixel was cleared during the last draw
//
// Build option: define SPRITE_WRAP_EN to wrap sprites around the screen edges
// instead of clipping them (every row is then a full 6-cycle row).
module sprite_blitter #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              res,
  input  logic              hires,
  input  logic              start,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [3:0]        n,
  input  logic [MEM_AW-1:0] i_addr,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [8:0]        fbuf_addr,
  input  logic [15:0]       fbuf_rdata,
  output logic [15:0]       fbuf_wdata,
  output logic              fbuf_we,
  output logic              busy,
  output logic              done,
  output logic              collision
);

`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, FETCH2, RD0, WR0, RD1, WR1, DONE} state_t;

  state_t            state;
  logic              hr;     // screen mode captured at start
  logic              wide;   // 16-pixel rows, two bytes each
  logic [6:0]        x0;
  logic [5:0]        y0;
  logic [4:0]        rows;
  logic [4:0]        r;
  logic [MEM_AW-1:0] ptr;
  logic [7:0]        hi;
  logic [31:0]       mask;   // row pattern aligned across word0 (31:16) and word1 (15:0)

  // x[7] and y[6] never affect the wrapped coordinates.
  logic unused_ok;
  assign unused_ok = ^{x[7], y[6]};

  logic [6:0]        y_sum;
  logic [5:0]        y_line;
  logic [2:0]        wi, wi1;
  logic [8:0]        line_base, word0, word1;
  logic              last_word, skip_w1, last_row;
  logic [MEM_AW-1:0] ptr_next;
  logic [15:0]       row16, cur_mask;

  always_comb begin
    y_sum     = {1'b0, y0} + {2'b0, r};
    // Masking to the screen height gives the wrapped line; in clip mode rows
    // past the bottom are never addressed, so the mask is harmless there.
    y_line    = hr ? y_sum[5:0] : {1'b0, y_sum[4:0]};
    line_base = hr ? {y_line, 3'b000} : {2'b00, y_line[4:0], 2'b00};
    wi        = hr ? x0[6:4] : {1'b0, x0[5:4]};
    wi1       = hr ? wi + 3'd1 : {1'b0, wi[1:0] + 2'd1};
    word0     = line_base + {6'b0, wi};
    word1     = line_base + {6'b0, wi1};
    last_word = hr ? (wi == 3'd7) : (wi == 3'd3);
    skip_w1   = !WRAP && last_word;
    last_row  = (r + 5'd1 == rows) ||
                (!WRAP && (y_sum + 7'd1 >= (hr ? 7'd64 : 7'd32)));
    ptr_next  = ptr + (wide ? MEM_AW'(2) : MEM_AW'(1));
    row16     = wide ? {hi, mem_data} : {hi, 8'h00};
    cur_mask  = (state == WR0) ? mask[31:16] : mask[15:0];
  end

  // Read data only arrives in the write cycle, so the write side is a direct
  // function of the state register and the returning word.
  always_comb begin
    fbuf_we    = 1'b0;
    fbuf_wdata = '0;
    if (state == WR0 || state == WR1) begin
      fbuf_we    = 1'b1;
      fbuf_wdata = fbuf_rdata ^ cur_mask;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      mem_addr  <= '0;
      fbuf_addr <= '0;
      done      <= 1'b0;
      collision <= 1'b0;
      hr        <= 1'b0;
      wide      <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      rows      <= '0;
      r         <= '0;
      ptr       <= '0;
      hi        <= '0;
      mask      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          hr        <= hires;
          wide      <= hires && (n == 4'd0);
          x0        <= hires ? x[6:0] : {1'b0, x[5:0]};
          y0        <= hires ? y[5:0] : {1'b0, y[4:0]};
          rows      <= (hires && n == 4'd0) ? 5'd16 : {1'b0, n};
          r         <= '0;
          ptr       <= i_addr;
          mem_addr  <= i_addr;
          collision <= 1'b0;
          state     <= (!hires && n == 4'd0) ? DONE : FETCH;
        end
        FETCH: begin
          if (wide) mem_addr <= ptr + MEM_AW'(1);
          state <= FETCH2;
        end
        FETCH2: begin
          hi        <= mem_data;
          fbuf_addr <= word0;
          state     <= RD0;
        end
        RD0: begin
          mask  <= {row16, 16'h0000} >> x0[3:0];
          state <= WR0;
        end
        RD1: state <= WR1;
        WR0, WR1: begin
          collision <= collision | (|(fbuf_rdata & cur_mask));
          if (state == WR0 && !skip_w1) begin
            fbuf_addr <= word1;
            state     <= RD1;
          end else begin
            ptr <= ptr_next;
            r   <= r + 5'd1;
            if (last_row) begin
              state <= DONE;
            end else begin
              mem_addr <= ptr_next;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res, hires, start;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr, mem_addr;
  logic [7:0]  mem_data;
  logic [8:0]  fbuf_addr;
  logic [15:0] fbuf_rdata, fbuf_wdata;
  logic        fbuf_we, busy, done, collision;

  always #5 clk = ~clk;

  sprite_blitter #(.MEM_AW(12)) dut (
    .clk(clk), .res(res), .hires(hires), .start(start), .x(x), .y(y), .n(n),
    .i_addr(i_addr), .mem_addr(mem_addr), .mem_data(mem_data),
    .fbuf_addr(fbuf_addr), .fbuf_rdata(fbuf_rdata), .fbuf_wdata(fbuf_wdata),
    .fbuf_we(fbuf_we), .busy(busy), .done(done), .collision(collision)
  );

  // Environment: sprite memory and framebuffer, both with one-cycle read latency.
  logic [7:0]  smem [4096];
  logic [15:0] fb   [512];
  logic        clr_fb = 1'b0;

  always @(posedge clk) begin
    mem_data   <= smem[mem_addr];
    fbuf_rdata <= fb[fbuf_addr];
    if (clr_fb) begin
      for (int i = 0; i < 512; i++) fb[i] <= 16'h0000;
    end else if (fbuf_we) begin
      fb[fbuf_addr] <= fbuf_wdata;
    end
  end

  // Reference framebuffer, updated pixel by pixel.
  logic [15:0] rf [512];

  int checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_draw(input bit hr, input logic [7:0] xi, input logic [6:0] yi,
                          input logic [3:0] ni, input logic [11:0] ia,
                          output bit coll, output int cyc, output int nwe);
    int w, h, wpl, x0, y0, rows, py, px, addr, b;
    bit wide;
    logic [11:0] a;
    logic [15:0] bits;
    w = hr ? 128 : 64; h = hr ? 64 : 32; wpl = hr ? 8 : 4;
    x0 = int'(xi) % w; y0 = int'(yi) % h;
    wide = hr && (ni == 0);
    rows = wide ? 16 : int'(ni);
    coll = 0; cyc = 2; nwe = 0;
    for (int r = 0; r < rows; r++) begin
      py = y0 + r;
      if (py >= h) begin
        if (WRAP) py -= h;
        else break;
      end
      a = ia + 12'(wide ? 2 * r : r);
      bits = wide ? {smem[a], smem[a + 12'd1]} : {smem[a], 8'h00};
      for (int c = 0; c < 16; c++) begin
        if (bits[15 - c]) begin
          px = x0 + c;
          if (px >= w) begin
            if (WRAP) px -= w;
            else continue;
          end
          addr = py * wpl + px / 16;
          b = 15 - px % 16;
          if (rf[addr][b]) coll = 1;
          rf[addr][b] = ~rf[addr][b];
        end
      end
      if (!WRAP && (x0 / 16 == wpl - 1)) begin cyc += 4; nwe += 1; end
      else begin cyc += 6; nwe += 2; end
    end
  endtask

  int lat;

  task automatic run(input string tag, input bit hr, input logic [7:0] xi,
                     input logic [6:0] yi, input logic [3:0] ni, input logic [11:0] ia);
    bit ecoll;
    int ecyc, enwe, cyc, wes, diffs;
    ref_draw(hr, xi, yi, ni, ia, ecoll, ecyc, enwe);
    @(negedge clk);
    hires = hr; x = xi; y = yi; n = ni; i_addr = ia; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; wes = 0;
    while (!done && cyc < 1000) begin
      if (fbuf_we) wes++;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    chk({tag, "_latency"}, cyc, ecyc);
    chk({tag, "_collision"}, collision, ecoll);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_we_count"}, wes, enwe);
    diffs = 0;
    for (int i = 0; i < 512; i++) begin
      if (fb[i] !== rf[i]) begin
        if (diffs == 0) $display("  first differing word %0d: fbuf 0x%0h model 0x%0h", i, fb[i], rf[i]);
        diffs++;
      end
    end
    chk({tag, "_fbuf_words_differing"}, diffs, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) smem[i] = 8'($urandom);
    for (int i = 0; i < 512; i++) rf[i] = 16'h0000;
    res = 1'b1; start = 1'b0; hires = 1'b0; x = '0; y = '0; n = '0; i_addr = '0;
    clr_fb = 1'b1;
    repeat (3) @(negedge clk);
    clr_fb = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_we", fbuf_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'h000);
    chk("rst_fbuf_addr", fbuf_addr, 9'h000);
    chk("rst_wdata", fbuf_wdata, 16'h0000);
    res = 1'b0;

    // Single lores row at the origin, then the same draw to erase it.
    smem[100] = 8'hF0;
    run("lo_origin", 1'b0, 8'd0, 7'd0, 4'd1, 12'd100);
    chk("lo_origin_w0", fb[0], 16'hF000);
    chk("lo_origin_w1", fb[1], 16'h0000);
    chk("lo_origin_lat8", lat, 8);
    chk("lo_origin_col0", collision, 1'b0);
    run("lo_erase", 1'b0, 8'd0, 7'd0, 4'd1, 12'd100);
    chk("lo_erase_w0", fb[0], 16'h0000);
    chk("lo_erase_col1", collision, 1'b1);

    // Row straddling a word boundary.
    smem[200] = 8'hFF;
    run("lo_straddle", 1'b0, 8'd12, 7'd3, 4'd1, 12'd200);
    chk("lo_straddle_a12", fb[12], 16'h000F);
    chk("lo_straddle_a13", fb[13], 16'hF000);

    // 16x16 at the bottom-right corner of the hires screen.
    run("hi_corner", 1'b1, 8'd120, 7'd60, 4'd0, 12'd300);
    chk("hi_corner_lat", lat, WRAP ? 98 : 18);

    // Coordinates beyond the lores screen wrap at start.
    run("lo_wrapxy", 1'b0, 8'd70, 7'd40, 4'd3, 12'd400);

    // lores n=0 is a no-op.
    run("lo_n0", 1'b0, 8'd5, 7'd5, 4'd0, 12'd500);
    chk("lo_n0_lat2", lat, 2);

    // Reset in WR0 of row 2 of a draw that has already collided.
    for (int i = 0; i < 4; i++) smem[600 + i] = 8'hFF;
    run("pre_reset", 1'b0, 8'd0, 7'd0, 4'd4, 12'd600);
    @(negedge clk);
    x = 8'd0; y = 7'd0; n = 4'd4; i_addr = 12'd600; hires = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_we_in_wr0", fbuf_we, 1'b1);
    chk("midrst_busy_before", busy, 1'b1);
    chk("midrst_col_before", collision, 1'b1);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_we", fbuf_we, 1'b0);
    chk("midrst_collision", collision, 1'b0);
    clr_fb = 1'b1;
    @(negedge clk);
    clr_fb = 1'b0;
    for (int i = 0; i < 512; i++) rf[i] = 16'h0000;

    // Random draws against the model.
    for (int k = 0; k < 30; k++) begin
      run($sformatf("rnd%0d", k), 1'($urandom), 8'($urandom), 7'($urandom),
          4'($urandom), 12'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
